// File: rtl/booth_divide_fsmd_pkg.sv
// Shared constants, FSMD state encoding and sign/magnitude helper for the arithmetic FSMDs.
// The Booth multiplier reuses ARITH_DATA_SIZE as its width.
package arith_fsmd_pkg;

    localparam int ARITH_DATA_SIZE = 8;
    localparam int ARITH_MAX_W     = 64;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_NORMALIZE = 2'b01,
        ST_ITERATE   = 2'b10,
        ST_FINISH    = 2'b11
    } fsmd_state_e;

    // Callers sign-extend into the wide argument and truncate the result.
    // This keeps one helper usable for any operand width.
    function automatic logic [ARITH_MAX_W-1:0] sign_mag(input logic signed [ARITH_MAX_W-1:0] v);
        return v[ARITH_MAX_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/booth_divide_fsmd_sign_fix.sv
// Combinational sign correction for the divider: applies result signs and special-case overrides.
// A zero divisor forces an all-ones quotient; the remainder then equals the dividend naturally.
module div_sign_fix
    import arith_fsmd_pkg::*;
#(
    parameter int DATA_SIZE = ARITH_DATA_SIZE
) (
    input  logic [DATA_SIZE-1:0] q_mag_i,
    input  logic [DATA_SIZE-1:0] r_mag_i,
    input  logic                 q_neg_i,
    input  logic                 r_neg_i,
    input  logic                 div_by_zero_i,
    input  logic                 overflow_i,
    output logic [DATA_SIZE-1:0] quotient_o,
    output logic [DATA_SIZE-1:0] remainder_o,
    output logic                 div_by_zero_o,
    output logic                 overflow_o
);

    always_comb begin
        quotient_o    = q_neg_i ? -q_mag_i : q_mag_i;
        remainder_o   = r_neg_i ? -r_mag_i : r_mag_i;
        div_by_zero_o = div_by_zero_i;
        overflow_o    = overflow_i & ~div_by_zero_i;
        if (div_by_zero_i) begin
            quotient_o = '1;
        end
    end

endmodule

// File: rtl/booth_divide_fsmd.sv
// Multi-cycle signed restoring divider FSMD: one shift-subtract step per cycle, DATA_SIZE+3 cycles per result.
// Defining BOOTH_DIVIDE_DEBUG_EN adds register tap ports (state, count, remainder, quotient shifter).
module booth_divide_fsmd
    import arith_fsmd_pkg::*;
#(
    parameter int DATA_SIZE = ARITH_DATA_SIZE
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [DATA_SIZE-1:0] dividend_i,
    input  logic [DATA_SIZE-1:0] divisor_i,
    output logic                 busy_o,
    output logic                 data_valid_o,
    output logic [DATA_SIZE-1:0] quotient_o,
    output logic [DATA_SIZE-1:0] remainder_o,
    output logic                 div_by_zero_o,
    output logic                 overflow_o
`ifdef BOOTH_DIVIDE_DEBUG_EN
    ,
    output logic [1:0]           current_state_o,
    output logic [7:0]           count_debug,
    output logic [DATA_SIZE-1:0] rem_debug,
    output logic [DATA_SIZE-1:0] q_debug
`endif
);

    localparam int                   CW       = $clog2(DATA_SIZE);
    localparam logic [CW-1:0]        CNT_LAST = CW'(DATA_SIZE - 1);
    localparam logic [DATA_SIZE-1:0] MOST_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};

    fsmd_state_e          state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DATA_SIZE:0]   r_q, r_d;
    logic [DATA_SIZE-1:0] q_q, q_d;
    logic [DATA_SIZE-1:0] dvs_q, dvs_d;
    logic                 qsign_q, qsign_d;
    logic                 rsign_q, rsign_d;
    logic                 dbz_q, dbz_d;
    logic                 ovf_q, ovf_d;
    logic                 valid_q, valid_d;
    logic [DATA_SIZE-1:0] quo_q, quo_d;
    logic [DATA_SIZE-1:0] rem_q, rem_d;
    logic                 dbz_out_q, dbz_out_d;
    logic                 ovf_out_q, ovf_out_d;

    logic [DATA_SIZE+1:0] shifted;
    logic [DATA_SIZE+1:0] trial;
    logic [DATA_SIZE-1:0] q_mag;
    logic [DATA_SIZE-1:0] dvs_mag;
    logic [DATA_SIZE-1:0] fix_quo;
    logic [DATA_SIZE-1:0] fix_rem;
    logic                 fix_dbz;
    logic                 fix_ovf;

    // Operands are held raw until NORMALIZE; the most-negative value maps to 2^(N-1) unsigned.
    assign q_mag   = DATA_SIZE'(sign_mag(ARITH_MAX_W'($signed(q_q))));
    assign dvs_mag = DATA_SIZE'(sign_mag(ARITH_MAX_W'($signed(dvs_q))));

    // r_q[DATA_SIZE] is always zero here; the extra top bit makes the trial sign bit exact.
    assign shifted = {r_q, q_q[DATA_SIZE-1]};
    assign trial   = shifted - {2'b00, dvs_q};

    div_sign_fix #(
        .DATA_SIZE(DATA_SIZE)
    ) u_sign_fix (
        .q_mag_i      (q_q),
        .r_mag_i      (r_q[DATA_SIZE-1:0]),
        .q_neg_i      (qsign_q),
        .r_neg_i      (rsign_q),
        .div_by_zero_i(dbz_q),
        .overflow_i   (ovf_q),
        .quotient_o   (fix_quo),
        .remainder_o  (fix_rem),
        .div_by_zero_o(fix_dbz),
        .overflow_o   (fix_ovf)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        r_d       = r_q;
        q_d       = q_q;
        dvs_d     = dvs_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_out_d = dbz_out_q;
        ovf_out_d = ovf_out_q;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (enable_i) begin
                    q_d     = dividend_i;
                    dvs_d   = divisor_i;
                    qsign_d = dividend_i[DATA_SIZE-1] ^ divisor_i[DATA_SIZE-1];
                    rsign_d = dividend_i[DATA_SIZE-1];
                    dbz_d   = (divisor_i == '0);
                    ovf_d   = (dividend_i == MOST_NEG) && (divisor_i == '1);
                    state_d = ST_NORMALIZE;
                end
            end
            ST_NORMALIZE: begin
                q_d     = q_mag;
                dvs_d   = dvs_mag;
                r_d     = '0;
                count_d = CNT_LAST;
                state_d = ST_ITERATE;
            end
            ST_ITERATE: begin
                if (!trial[DATA_SIZE+1]) begin
                    r_d = trial[DATA_SIZE:0];
                    q_d = {q_q[DATA_SIZE-2:0], 1'b1};
                end else begin
                    r_d = shifted[DATA_SIZE:0];
                    q_d = {q_q[DATA_SIZE-2:0], 1'b0};
                end
                count_d = count_q - CW'(1);
                if (count_q == '0) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                quo_d     = fix_quo;
                rem_d     = fix_rem;
                dbz_out_d = fix_dbz;
                ovf_out_d = fix_ovf;
                valid_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            r_q       <= '0;
            q_q       <= '0;
            dvs_q     <= '0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_out_q <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            r_q       <= r_d;
            q_q       <= q_d;
            dvs_q     <= dvs_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dbz_out_q <= dbz_out_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign data_valid_o  = valid_q;
    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_out_q;
    assign overflow_o    = ovf_out_q;

`ifdef BOOTH_DIVIDE_DEBUG_EN
    assign current_state_o = state_q;
    assign count_debug     = 8'(count_q);
    assign rem_debug       = r_q[DATA_SIZE-1:0];
    assign q_debug         = q_q;
`endif

endmodule

// File: tb/tb_booth_divide_fsmd.sv
// Self-checking bench for booth_divide_fsmd at DATA_SIZE=8: directed cases, reset abort, back-to-back, randomized reference compare.
module tb_booth_divide_fsmd;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       enable_i;
    logic [7:0] dividend_i;
    logic [7:0] divisor_i;
    logic       busy_o;
    logic       data_valid_o;
    logic [7:0] quotient_o;
    logic [7:0] remainder_o;
    logic       div_by_zero_o;
    logic       overflow_o;
`ifdef BOOTH_DIVIDE_DEBUG_EN
    logic [1:0] current_state_o;
    logic [7:0] count_debug;
    logic [7:0] rem_debug;
    logic [7:0] q_debug;
`endif

    int checks   = 0;
    int failures = 0;

    booth_divide_fsmd #(.DATA_SIZE(8)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .busy_o       (busy_o),
        .data_valid_o (data_valid_o),
        .quotient_o   (quotient_o),
        .remainder_o  (remainder_o),
        .div_by_zero_o(div_by_zero_o),
        .overflow_o   (overflow_o)
`ifdef BOOTH_DIVIDE_DEBUG_EN
        ,
        .current_state_o(current_state_o),
        .count_debug    (count_debug),
        .rem_debug      (rem_debug),
        .q_debug        (q_debug)
`endif
    );

    always #5 clk = ~clk;

    // Reference: truncating signed division with the two architected special cases.
    function automatic void ref_div(input int a, input int b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic dz, output logic ov);
        if (b == 0) begin
            q = 8'hFF; r = 8'(a); dz = 1'b1; ov = 1'b0;
        end else if (a == -128 && b == -1) begin
            q = 8'h80; r = 8'h00; dz = 1'b0; ov = 1'b1;
        end else begin
            q = 8'(a / b); r = 8'(a % b); dz = 1'b0; ov = 1'b0;
        end
    endfunction

    // Starts one operation from IDLE (called #1 after an edge) and waits for the valid pulse.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic dz, output logic ov,
                          output int lat, output logic busy_seen);
        enable_i   = 1'b1;
        dividend_i = a;
        divisor_i  = b;
        @(posedge clk); #1;
        enable_i   = 1'b0;
        dividend_i = 8'($urandom);
        divisor_i  = 8'($urandom);
        busy_seen  = busy_o;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (data_valid_o) begin
                lat = i;
                break;
            end
        end
        q  = quotient_o;
        r  = remainder_o;
        dz = div_by_zero_o;
        ov = overflow_o;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; enable_i = 1'b0; dividend_i = 8'h55; divisor_i = 8'h33;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        checks++;
        if ({busy_o, data_valid_o, quotient_o, remainder_o, div_by_zero_o, overflow_o} !== 20'h0) begin
            failures++;
            $display("FAIL reset_state got busy=%b vld=%b q=%h r=%h dz=%b ov=%b exp all zero",
                     busy_o, data_valid_o, quotient_o, remainder_o, div_by_zero_o, overflow_o);
        end
    endtask

    task automatic test_basic();
        logic [7:0] q, r; logic dz, ov, bs; int lat;
        run_op(8'd100, 8'd7, q, r, dz, ov, lat, bs);
        checks++;
        if (bs !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bs); end
        checks++;
        if (lat !== 10) begin failures++; $display("FAIL basic_latency got=%0d exp=10", lat); end
        checks++;
        if ({q, r, dz, ov} !== {8'h0E, 8'h02, 2'b00}) begin
            failures++;
            $display("FAIL basic_100_7 got q=%h r=%h dz=%b ov=%b exp q=0e r=02 dz=0 ov=0", q, r, dz, ov);
        end
        @(posedge clk); #1;
        checks++;
        if (data_valid_o !== 1'b0 || quotient_o !== 8'h0E || remainder_o !== 8'h02) begin
            failures++;
            $display("FAIL basic_pulse_hold got vld=%b q=%h r=%h exp vld=0 q=0e r=02",
                     data_valid_o, quotient_o, remainder_o);
        end
    endtask

    task automatic test_signs();
        logic [7:0] q, r; logic dz, ov, bs; int lat;
        run_op(-8'sd100, 8'd7, q, r, dz, ov, lat, bs);
        checks++;
        if ({q, r, dz, ov} !== {8'hF2, 8'hFE, 2'b00}) begin
            failures++;
            $display("FAIL signs_m100_7 got q=%h r=%h dz=%b ov=%b exp q=f2 r=fe", q, r, dz, ov);
        end
        run_op(8'd7, -8'sd100, q, r, dz, ov, lat, bs);
        checks++;
        if ({q, r, dz, ov} !== {8'h00, 8'h07, 2'b00}) begin
            failures++;
            $display("FAIL signs_7_m100 got q=%h r=%h dz=%b ov=%b exp q=00 r=07", q, r, dz, ov);
        end
    endtask

    task automatic test_special();
        logic [7:0] q, r; logic dz, ov, bs; int lat;
        run_op(8'h80, 8'hFF, q, r, dz, ov, lat, bs);
        checks++;
        if ({q, r, dz, ov} !== {8'h80, 8'h00, 2'b01}) begin
            failures++;
            $display("FAIL special_overflow got q=%h r=%h dz=%b ov=%b exp q=80 r=00 dz=0 ov=1", q, r, dz, ov);
        end
        run_op(8'd5, 8'd0, q, r, dz, ov, lat, bs);
        checks++;
        if ({q, r, dz, ov} !== {8'hFF, 8'h05, 2'b10} || lat !== 10) begin
            failures++;
            $display("FAIL special_div0 got q=%h r=%h dz=%b ov=%b lat=%0d exp q=ff r=05 dz=1 ov=0 lat=10",
                     q, r, dz, ov, lat);
        end
    endtask

    task automatic test_abort_reset();
        logic [7:0] q, r; logic dz, ov, bs; int lat; bit seen;
        enable_i = 1'b1; dividend_i = 8'd100; divisor_i = 8'd7;
        @(posedge clk); #1;
        enable_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 enable_i = 1'b1; dividend_i = 8'd50; divisor_i = 8'd5;
        @(posedge clk); #1;
        enable_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL abort_busy_midop got=%b exp=1", busy_o); end
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        checks++;
        if ({busy_o, data_valid_o, quotient_o, remainder_o, div_by_zero_o, overflow_o} !== 20'h0) begin
            failures++;
            $display("FAIL abort_outputs got busy=%b vld=%b q=%h r=%h dz=%b ov=%b exp all zero",
                     busy_o, data_valid_o, quotient_o, remainder_o, div_by_zero_o, overflow_o);
        end
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (data_valid_o || busy_o) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_pulse got activity=1 exp=0"); end
        run_op(8'd50, 8'd5, q, r, dz, ov, lat, bs);
        checks++;
        if ({q, r, dz, ov} !== {8'h0A, 8'h00, 2'b00} || lat !== 10) begin
            failures++;
            $display("FAIL abort_recover got q=%h r=%h lat=%0d exp q=0a r=00 lat=10", q, r, lat);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        enable_i = 1'b1; dividend_i = 8'd127; divisor_i = 8'd3;
        @(posedge clk); #1;
        dividend_i = -8'sd127;
        t1 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (data_valid_o) begin t1 = i; break; end
        end
        checks++;
        if (t1 !== 10 || quotient_o !== 8'd42 || remainder_o !== 8'd1) begin
            failures++;
            $display("FAIL b2b_first got lat=%0d q=%h r=%h exp lat=10 q=2a r=01", t1, quotient_o, remainder_o);
        end
        @(posedge clk); #1;
        enable_i = 1'b0;
        t2 = 0;
        for (int i = 2; i <= 40; i++) begin
            @(posedge clk); #1;
            if (data_valid_o) begin t2 = i; break; end
        end
        checks++;
        if (t2 !== 11 || quotient_o !== 8'hD6 || remainder_o !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_second got spacing=%0d q=%h r=%h exp spacing=11 q=d6 r=ff",
                     t2, quotient_o, remainder_o);
        end
    endtask

    task automatic test_corners();
        logic [7:0] q, r, eq, er; logic dz, ov, edz, eov, bs; int lat;
        for (int d = 0; d < 256; d++) begin
            for (int k = 0; k < 3; k++) begin
                logic [7:0] a, b;
                a = (k == 2) ? 8'h80 : 8'(d);
                b = (k == 0) ? 8'h00 : ((k == 1) ? 8'hFF : 8'(d));
                run_op(a, b, q, r, dz, ov, lat, bs);
                ref_div(int'($signed(a)), int'($signed(b)), eq, er, edz, eov);
                checks++;
                if ({q, r, dz, ov} !== {eq, er, edz, eov} || lat !== 10) begin
                    failures++;
                    $display("FAIL corner a=%h b=%h got q=%h r=%h dz=%b ov=%b lat=%0d exp q=%h r=%h dz=%b ov=%b lat=10",
                             a, b, q, r, dz, ov, lat, eq, er, edz, eov);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] q, r, eq, er, a, b; logic dz, ov, edz, eov, bs; int lat;
        for (int n = 0; n < 2500; n++) begin
            a = 8'($urandom);
            case ($urandom_range(0, 9))
                0:       b = 8'h00;
                1:       b = 8'hFF;
                2:       b = 8'h80;
                default: b = 8'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) a = 8'h80;
            run_op(a, b, q, r, dz, ov, lat, bs);
            ref_div(int'($signed(a)), int'($signed(b)), eq, er, edz, eov);
            checks++;
            if ({q, r, dz, ov} !== {eq, er, edz, eov} || lat !== 10) begin
                failures++;
                $display("FAIL random a=%h b=%h got q=%h r=%h dz=%b ov=%b lat=%0d exp q=%h r=%h dz=%b ov=%b lat=10",
                         a, b, q, r, dz, ov, lat, eq, er, edz, eov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_special();
        test_abort_reset();
        test_back_to_back();
        test_corners();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
